// File: rtl/mult16_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult16_seq (with helper fulladder_16bit)
// Description : Sequential 16x16 unsigned shift-and-add multiplier. A single
//               16-bit ripple-carry adder is reused for 16 steps. Each step
//               adds the multiplicand into the high partial product when the
//               current multiplier LSB is set. It then shifts {C,S,Q} right by
//               one bit.
//               Valid/ready handshakes are used on both the input and output
//               sides.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   operands present
//               in_ready   block can accept operands (IDLE only)
//               a, b       16-bit unsigned multiplicand / multiplier
//               out_valid  product available (DONE only)
//               out_ready  consumer takes product
//               product    32-bit unsigned a*b, meaningful while out_valid=1
// Option      : MULT16_ZERO_SKIP_EN - a zero operand on the accept edge goes
//               straight to DONE with a zero product. This gives a latency of
//               1 edge instead of 16.
// Revision    : 1.0 - initial release
// ============================================================================

module fulladder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[16];
endmodule

module mult16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_a;
    logic [15:0] r_p;
    logic [15:0] r_q;
    logic [4:0]  r_cnt;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_accept;
    logic        w_zero;

    // Multiplier LSB gates whether the multiplicand is added this step.
    assign w_addend = r_q[0] ? r_a : 16'h0000;

    fulladder_16bit u_adder (
        .a    (r_p),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_accept = in_valid && in_ready;

`ifdef MULT16_ZERO_SKIP_EN
    assign w_zero = (a == 16'h0000) || (b == 16'h0000);
`else
    assign w_zero = 1'b0;
`endif

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == 5'd15) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 16'h0000;
            r_p   <= 16'h0000;
            r_q   <= 16'h0000;
            r_cnt <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_p   <= 16'h0000;
                        // A skipped operation leaves Q cleared so that the
                        // product reads zero in DONE.
                        r_q   <= w_zero ? 16'h0000 : b;
                        r_cnt <= 5'd0;
                    end
                end
                RUN: begin
                    // Right shift of the 33-bit {C,S,Q}. Q[0] is consumed
                    // and the carry-out enters the top of P.
                    {r_p, r_q} <= {w_cout, w_sum, r_q[15:1]};
                    r_cnt      <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign product = {r_p, r_q};

endmodule
`default_nettype wire

// File: tb/tb_mult16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult16_seq
// Description : Self-checking bench for mult16_seq. It uses directed
//               operand vectors with literal expectations. An abstract
//               transaction model predicts in_ready, out_valid and the
//               product on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult16_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mult16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // The model only knows that a transaction is accepted when idle. It
    // yields a*b a fixed number of edges later and is released by out_ready.
    bit          m_idle = 1'b1;
    int          m_wait = 0;
    logic [31:0] m_prod = 32'h0;

    function automatic int lat_of(input logic [15:0] x, input logic [15:0] y);
`ifdef MULT16_ZERO_SKIP_EN
        if (x == 16'h0 || y == 16'h0) return 1;
`endif
        return 16;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1;
            m_wait = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_prod = 32'(a) * 32'(b);
                m_wait = lat_of(a, b);
            end
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end else if (out_ready) begin
            m_idle = 1'b1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_in_ready", {31'b0, in_ready}, {31'b0, m_idle});
            chk("model_out_valid", {31'b0, out_valid}, {31'b0, (!m_idle && m_wait == 0)});
            if (!m_idle && m_wait == 0) chk("model_product", product, m_prod);
        end
    end

    // One full transaction with literal expectations. hold>0 keeps out_ready
    // low for that many cycles after the result appears.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [31:0] exp, input int lat, input int hold);
        int  n;
        bit  got;
        @(negedge clk);
        out_ready = (hold == 0);
        a = ta; b = tb_; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) got = 1'b1;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("product", product, exp);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = ~in_valid;
                a = 16'($urandom); b = 16'($urandom);
                chk("bp_product", product, exp);
                chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int last;
        bit found;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        #23;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(16'd3, 16'd5, 32'h0000000F, 16, 0);
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 0);
        run_op(16'h8000, 16'h0002, 32'h00010000, 16, 0);
        run_op(16'd1000, 16'd1000, 32'd1000000, 16, 5);

        // Abort mid-run
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd7, 16'd9, 32'd63, 16, 0);

        run_op(16'h0000, 16'h1234, 32'd0, lat_of(16'h0000, 16'h1234), 0);

        // Back-to-back random pairs: a new operand pair is presented as soon as
        // the block is idle. Accepts are spaced by the initiation interval.
        last = 0;
        for (int k = 0; k < 100; k++) begin
            found = 1'b0;
            for (int w = 0; w < 40 && !found; w++) begin
                @(negedge clk);
                if (in_ready) begin
                    found = 1'b1;
                    a = 16'($urandom_range(1, 65535));
                    b = 16'($urandom_range(1, 65535));
                    in_valid = 1'b1;
                    if (k > 0) chk("interval", 32'(cyc - last), 32'd18);
                    last = cyc;
                end
            end
            if (!found) chk("b2b_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
